mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath. It replaces single-cycle decode with a Moore FSM

---
 rtl/mips_pkg.sv | 68 ++++++
 rtl/mips_mc_decode.sv | 42 ++++
 rtl/mips_multicycle_ctrl.sv | 173 +++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS codes: sequencer states, ALU operation codes, opcode/funct
// constants and the instruction classes produced by the decoder.
package mips_pkg;

  // Sequencer states; the encoding is exported on state_o for debug.
  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_R     = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_WB_MEM   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  // ALU operation codes, shared with the ALU and the single-cycle decoder.
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_NOR = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Opcodes (IR[31:26]).
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;

  // R-type funct codes (IR[5:0]).
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  // Instruction classes that select the path out of DECODE.
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_J   = 3'd4,
    CLS_JR  = 3'd5,
    CLS_ILL = 3'd6
  } cls_t;

  // States that own the shared memory port and wait on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: (opcode, funct) -> class, ALU op for
// the execute step, and whether the immediate is zero-extended.
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output cls_t       cls,
  output logic [3:0] alu_op,
  output logic       imm_zext
);

  // Table lookup; anything not listed is illegal and leads to TRAP.
  always_comb begin
    cls      = CLS_ILL;
    alu_op   = ALU_NOP;
    imm_zext = 1'b0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_ADD:          begin cls = CLS_R; alu_op = ALU_ADD; end
          FN_AND:          begin cls = CLS_R; alu_op = ALU_AND; end
          FN_OR:           begin cls = CLS_R; alu_op = ALU_OR;  end
          FN_NOR:          begin cls = CLS_R; alu_op = ALU_NOR; end
          FN_SUB, FN_SUBU: begin cls = CLS_R; alu_op = ALU_SUB; end
          FN_SLT:          begin cls = CLS_R; alu_op = ALU_SLT; end
          FN_JR:           cls = CLS_JR;
          default:         cls = CLS_ILL;
        endcase
      end
      OPC_ADDI: begin cls = CLS_I; alu_op = ALU_ADD; end
      OPC_SLTI: begin cls = CLS_I; alu_op = ALU_SLT; end
      OPC_ANDI: begin cls = CLS_I; alu_op = ALU_AND; imm_zext = 1'b1; end
      OPC_ORI:  begin cls = CLS_I; alu_op = ALU_OR;  imm_zext = 1'b1; end
      OPC_LW:   cls = CLS_LW;
      OPC_SW:   cls = CLS_SW;
      OPC_J:    cls = CLS_J;
      default:  cls = CLS_ILL;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer. Moore FSM stepping FETCH/DECODE/EXEC/MEM/WB,
// with a mem_ready handshake, a memory wait timeout and a retired counter.
// Memory handshake: in FETCH, MEM_RD and MEM_WR the request is held steady
// until the cycle mem_ready=1, which completes the access and leaves the state;
// a wait that would bring wait_cnt to all-ones without mem_ready goes to TRAP.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             trap,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  // One below all-ones: the last count at which a wait may still complete.
  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = ~{{(TIMEOUT_W-1){1'b0}}, 1'b1};

  state_t               state, state_next;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 timeout;
  logic                 retire_now;
  logic                 is_lw_q;
  logic                 trap_q;
  logic [CNT_W-1:0]     retired_q;
  cls_t                 dec_cls;
  logic [3:0]           dec_alu_op;
  logic                 dec_zext;

  mips_mc_decode u_decode (
    .opcode   (opcode),
    .funct    (funct),
    .cls      (dec_cls),
    .alu_op   (dec_alu_op),
    .imm_zext (dec_zext)
  );

  assign timeout    = !mem_ready && (wait_cnt == WAIT_LAST);
  assign retire_now = (state == S_WB_R) || (state == S_WB_I) || (state == S_WB_MEM) ||
                      (state == S_JUMP) || (state == S_JR) ||
                      ((state == S_MEM_WR) && mem_ready);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:     if (run) state_next = S_FETCH;
      S_FETCH:    if (mem_ready) state_next = S_DECODE;
                  else if (timeout) state_next = S_TRAP;
      S_DECODE: begin
        case (dec_cls)
          CLS_R:          state_next = S_EXEC_R;
          CLS_I:          state_next = S_EXEC_I;
          CLS_LW, CLS_SW: state_next = S_MEM_ADDR;
          CLS_J:          state_next = S_JUMP;
          CLS_JR:         state_next = S_JR;
          default:        state_next = S_TRAP;
        endcase
      end
      S_EXEC_R:   state_next = S_WB_R;
      S_EXEC_I:   state_next = S_WB_I;
      S_MEM_ADDR: state_next = is_lw_q ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
                  else if (timeout) state_next = S_TRAP;
      S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
                  else if (timeout) state_next = S_TRAP;
      S_WB_R, S_WB_I, S_WB_MEM, S_JUMP, S_JR: state_next = S_FETCH;
      S_TRAP:     state_next = S_TRAP;
      default:    state_next = S_TRAP;
    endcase
  end

  // Moore output decode; pc_write in FETCH follows the completing handshake.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_NOP;
    pc_src     = 2'b00;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = dec_alu_op;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = dec_zext ? 2'b11 : 2'b10;
        alu_op    = dec_alu_op;
      end
      S_WB_R:     begin reg_write = 1'b1; reg_dst = 1'b1; end
      S_WB_I:     reg_write = 1'b1;
      S_MEM_ADDR: begin alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = ALU_ADD; end
      S_MEM_RD:   begin i_or_d = 1'b1; mem_read = 1'b1; end
      S_MEM_WR:   begin i_or_d = 1'b1; mem_write = 1'b1; end
      S_WB_MEM:   begin reg_write = 1'b1; mem_to_reg = 1'b1; end
      S_JUMP:     begin pc_write = 1'b1; pc_src = 2'b01; end
      S_JR:       begin pc_write = 1'b1; pc_src = 2'b10; end
      default:    ;
    endcase
  end

  // Wait counter restarts whenever no access is pending or one completes.
  always_ff @(posedge clk) begin
    if (reset || !is_mem_state(state) || mem_ready) wait_cnt <= '0;
    else                                            wait_cnt <= wait_cnt + 1'b1;
  end

  // Remember lw vs sw at DECODE so later opcode changes cannot redirect MEM_ADDR.
  always_ff @(posedge clk) begin
    if (reset)                  is_lw_q <= 1'b0;
    else if (state == S_DECODE) is_lw_q <= (dec_cls == CLS_LW);
  end

  // Sticky trap flag, set together with entry into TRAP.
  always_ff @(posedge clk) begin
    if (reset)                     trap_q <= 1'b0;
    else if (state_next == S_TRAP) trap_q <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset)           retired_q <= '0;
    else if (retire_now) retired_q <= retired_q + 1'b1;
  end

  assign trap    = trap_q;
  assign retired = retired_q;
  assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level model expands each
// instruction into its expected per-cycle output trace; one compare process
// checks every cycle, plus literal spot checks.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0]  st;
    logic        pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic        reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op;
    logic [1:0]  pc_src;
    logic        trap;
    logic [15:0] retired;
  } ov_t;
  localparam int OW = $bits(ov_t);

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_J = 4, K_JR = 5, K_ILL = 6;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready;
  logic [5:0]  opcode, funct;
  logic        pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst;
  logic        mem_to_reg, alu_src_a, trap;
  logic [1:0]  alu_src_b, pc_src;
  logic [3:0]  alu_op, state_o;
  logic [15:0] retired;

  logic [OW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_total = 0;
  int            n_bad   = 0;
  int            m_ret   = 0;
  logic          m_trap  = 1'b0;

  mips_multicycle_ctrl #(.TIMEOUT_W(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_src(pc_src), .trap(trap), .retired(retired), .state_o(state_o)
  );

  // Clock
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h20, 6'h24, 6'h25, 6'h27, 6'h22, 6'h23, 6'h2a: return K_R;
               6'h08: return K_JR;
               default: return K_ILL;
             endcase
      6'h08, 6'h0c, 6'h0d, 6'h0a: return K_I;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h02: return K_J;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 4'b0000;
      6'h24: return 4'b0001;
      6'h25: return 4'b0010;
      6'h27: return 4'b0011;
      6'h22, 6'h23: return 4'b0100;
      default: return 4'b0101;
    endcase
  endfunction

  function automatic logic [3:0] i_alu(input logic [5:0] op);
    case (op)
      6'h08: return 4'b0000;
      6'h0c: return 4'b0001;
      6'h0d: return 4'b0010;
      default: return 4'b0101;
    endcase
  endfunction

  // Quiet vector for a state: all enables 0, muxes 0, ALU NOP.
  function automatic ov_t v(input state_t s);
    ov_t e;
    e = '0;
    e.st = s;
    e.alu_op = 4'b1111;
    e.trap = m_trap;
    e.retired = 16'(m_ret);
    return e;
  endfunction

  function automatic ov_t fetch_v(input logic rdy);
    ov_t e;
    e = v(S_FETCH);
    e.mem_read = 1'b1; e.ir_write = 1'b1; e.alu_src_b = 2'b01; e.alu_op = 4'b0000;
    e.pc_write = rdy;
    return e;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic rdy, input ov_t e, input string tag);
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    opcode = 6'($urandom_range(0, 63));
    funct  = 6'($urandom_range(0, 63));
    run    = rnd();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // One instruction: fw fetch waits, mw data waits; abort resets in the first data wait.
  task automatic do_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                          input int fw, input int mw, input bit abort, output int cyc);
    ov_t e;
    int  k;
    int  c;
    c = 0;
    opcode = 6'h3f; funct = 6'h3f;
    for (int i = 0; i < fw; i++) begin cycle(1'b0, fetch_v(1'b0), {nm, "/fetch_wait"}); c++; end
    cycle(1'b1, fetch_v(1'b1), {nm, "/fetch"}); c++;
    opcode = op; funct = fn; run = rnd();
    e = v(S_DECODE); e.alu_src_b = 2'b10; e.alu_op = 4'b0000;
    cycle(rnd(), e, {nm, "/decode"}); c++;
    k = kind_of(op, fn);
    case (k)
      K_R: begin
        e = v(S_EXEC_R); e.alu_src_a = 1'b1; e.alu_op = r_alu(fn);
        cycle(rnd(), e, {nm, "/exec_r"}); c++;
        scramble();
        e = v(S_WB_R); e.reg_write = 1'b1; e.reg_dst = 1'b1;
        cycle(rnd(), e, {nm, "/wb_r"}); c++; m_ret++;
      end
      K_I: begin
        e = v(S_EXEC_I); e.alu_src_a = 1'b1; e.alu_op = i_alu(op);
        e.alu_src_b = (op == 6'h0c || op == 6'h0d) ? 2'b11 : 2'b10;
        cycle(rnd(), e, {nm, "/exec_i"}); c++;
        scramble();
        e = v(S_WB_I); e.reg_write = 1'b1;
        cycle(rnd(), e, {nm, "/wb_i"}); c++; m_ret++;
      end
      K_LW, K_SW: begin
        e = v(S_MEM_ADDR); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 4'b0000;
        cycle(rnd(), e, {nm, "/mem_addr"}); c++;
        scramble();
        e = v(k == K_LW ? S_MEM_RD : S_MEM_WR); e.i_or_d = 1'b1;
        if (k == K_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        if (abort) begin
          reset = 1'b1;
          cycle(1'b0, e, {nm, "/mem_abort"}); c++;
          reset = 1'b0; m_ret = 0; m_trap = 1'b0;
        end else begin
          for (int i = 0; i < mw; i++) begin cycle(1'b0, e, {nm, "/mem_wait"}); c++; end
          cycle(1'b1, e, {nm, "/mem"}); c++;
          if (k == K_LW) begin
            e = v(S_WB_MEM); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
            cycle(rnd(), e, {nm, "/wb_mem"}); c++;
          end
          m_ret++;
        end
      end
      K_J, K_JR: begin
        e = v(k == K_J ? S_JUMP : S_JR); e.pc_write = 1'b1;
        e.pc_src = (k == K_J) ? 2'b01 : 2'b10;
        scramble();
        cycle(rnd(), e, {nm, "/jump"}); c++; m_ret++;
      end
      default: begin
        m_trap = 1'b1;
        for (int i = 0; i < 4; i++) begin scramble(); cycle(rnd(), v(S_TRAP), {nm, "/trap"}); c++; end
      end
    endcase
    cyc = c;
  endtask

  // Reset from a known current state, then idle one cycle and launch.
  task automatic reset_from(input ov_t cur, input string tag);
    reset = 1'b1;
    cycle(rnd(), cur, tag);
    reset = 1'b0; m_ret = 0; m_trap = 1'b0;
    run = 1'b0;
    cycle(rnd(), v(S_IDLE), "idle_hold");
    run = 1'b1;
    cycle(rnd(), v(S_IDLE), "idle_go");
  endtask

  // ---------------- compare ----------------
  always @(negedge clk) begin
    logic [OW-1:0] want, got;
    string tag;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      got  = {state_o, pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
              mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, trap, retired};
      n_total++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL %s: got %h want %h", tag, got, want);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b0, v(S_IDLE), "reset_idle");
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'hf);
    chk("rst_retired", 32'(retired), 32'd0);
    run = 1'b1;
    cycle(1'b1, v(S_IDLE), "idle_go");

    do_instr("add", 6'h00, 6'h20, 0, 0, 1'b0, cyc);
    chk("add_cycles", 32'(cyc), 32'd4);
    chk("add_retired", 32'(retired), 32'd1);
    do_instr("lw", 6'h23, 6'h00, 0, 3, 1'b0, cyc);
    chk("lw_cycles", 32'(cyc), 32'd8);
    do_instr("j", 6'h02, 6'h11, 0, 0, 1'b0, cyc);
    chk("j_cycles", 32'(cyc), 32'd3);
    do_instr("jr", 6'h00, 6'h08, 1, 0, 1'b0, cyc);
    chk("jjr_retired", 32'(retired), 32'd4);
    do_instr("sub",  6'h00, 6'h22, 0, 0, 1'b0, cyc);
    do_instr("subu", 6'h00, 6'h23, 2, 0, 1'b0, cyc);
    do_instr("and",  6'h00, 6'h24, 0, 0, 1'b0, cyc);
    do_instr("or",   6'h00, 6'h25, 0, 0, 1'b0, cyc);
    do_instr("nor",  6'h00, 6'h27, 0, 0, 1'b0, cyc);
    do_instr("slt",  6'h00, 6'h2a, 0, 0, 1'b0, cyc);
    do_instr("addi", 6'h08, 6'h3f, 0, 0, 1'b0, cyc);
    do_instr("andi", 6'h0c, 6'h20, 0, 0, 1'b0, cyc);
    do_instr("ori",  6'h0d, 6'h00, 0, 0, 1'b0, cyc);
    do_instr("slti", 6'h0a, 6'h2a, 0, 0, 1'b0, cyc);
    do_instr("sw",   6'h2b, 6'h00, 0, 0, 1'b0, cyc);
    chk("sw_cycles", 32'(cyc), 32'd4);
    chk("sw_retired", 32'(retired), 32'd15);
    // 14 waits then ready on the cycle that would hit the terminal count.
    do_instr("add_tc", 6'h00, 6'h20, 14, 0, 1'b0, cyc);
    do_instr("sw_tc", 6'h2b, 6'h00, 0, 14, 1'b0, cyc);
    chk("tc_retired", 32'(retired), 32'd17);
    chk("tc_trap", 32'(trap), 32'd0);

    // Reset in the middle of a store.
    do_instr("sw_abort", 6'h2b, 6'h00, 0, 2, 1'b1, cyc);
    run = 1'b0;
    chk("abort_state", 32'(state_o), 32'd0);
    chk("abort_mem_write", 32'(mem_write), 32'd0);
    chk("abort_retired", 32'(retired), 32'd0);
    cycle(1'b0, v(S_IDLE), "abort_idle");
    run = 1'b1;
    cycle(1'b0, v(S_IDLE), "abort_go");

    // Illegal opcode, then illegal funct.
    do_instr("ill_op", 6'h3f, 6'h20, 0, 0, 1'b0, cyc);
    chk("ill_trap", 32'(trap), 32'd1);
    chk("ill_state", 32'(state_o), 32'd13);
    reset_from(v(S_TRAP), "ill_reset");
    do_instr("ill_fn", 6'h00, 6'h01, 0, 0, 1'b0, cyc);
    reset_from(v(S_TRAP), "ill_fn_reset");

    // Fetch timeout: mem_ready low for 15 cycles.
    opcode = 6'h00; funct = 6'h20;
    for (int i = 0; i < 15; i++) cycle(1'b0, fetch_v(1'b0), "to_fetch");
    m_trap = 1'b1;
    for (int i = 0; i < 3; i++) cycle(1'b0, v(S_TRAP), "to_trap");
    chk("to_trap", 32'(trap), 32'd1);
    reset_from(v(S_TRAP), "to_reset");
    chk("final_trap", 32'(trap), 32'd0);
    do_instr("add_end", 6'h00, 6'h20, 0, 0, 1'b0, cyc);
    chk("end_retired", 32'(retired), 32'd1);

    @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
